// File: rtl/eq_mac_scheduler.sv
// eq_mac_scheduler: shares one external 16x16 MAC across 8 bands x 15 taps per sample; ports: sample handshake in, coef config port in, MAC operand/control out, MAC acc in, band results out
module eq_mac_scheduler #(
  parameter int TAPS = 15,
  parameter int BANDS = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_in,
  output logic          sample_ready,
  input  logic          coef_we,
  input  logic [6:0]    coef_addr,
  input  logic [DW-1:0] coef_wdata,
  output logic          cfg_err,
  output logic          mac_en,
  output logic          mac_clr,
  output logic [DW-1:0] mac_coef,
  output logic [DW-1:0] mac_data,
  input  logic [31:0]   mac_acc,
  output logic          band_valid,
  output logic [2:0]    band_idx,
  output logic [31:0]   band_out,
  output logic          frame_done
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, WAIT} state_t;
  state_t state, state_nx;
  logic [DW-1:0] sample_q;
  logic [DW-1:0] dline [TAPS];
  logic [DW-1:0] coef [BANDS*TAPS];
  logic [2:0] band;
  logic [3:0] tap;
  logic [6:0] ridx, widx;
  logic coef_ok;
  assign sample_ready = state == IDLE;
  assign mac_en = state == RUN;
  assign mac_clr = mac_en && tap == 4'd0;
  assign ridx = {band, 4'b0} - {4'b0, band} + {3'b0, tap};
  assign widx = {coef_addr[6:4], 4'b0} - {4'b0, coef_addr[6:4]} + {3'b0, coef_addr[3:0]};
  assign coef_ok = sample_ready && coef_addr[3:0] != 4'hf;
  assign mac_coef = mac_en ? coef[ridx] : '0;
  assign mac_data = mac_en ? dline[tap] : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = sample_valid ? LOAD : IDLE;
      LOAD: state_nx = RUN;
      RUN:  state_nx = tap == 4'(TAPS - 1) ? WAIT : RUN;
      WAIT: state_nx = band == 3'(BANDS - 1) ? IDLE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sample_q <= '0;
      band <= '0;
      tap <= '0;
      band_valid <= 1'b0;
      frame_done <= 1'b0;
      band_idx <= '0;
      band_out <= '0;
      cfg_err <= 1'b0;
      for (int i = 0; i < TAPS; i++) dline[i] <= '0;
      for (int i = 0; i < BANDS*TAPS; i++) coef[i] <= '0;
    end else begin
      state <= state_nx;
      if (sample_ready && sample_valid) sample_q <= sample_in;
      if (state == LOAD) begin
        dline[0] <= sample_q;
        for (int i = 1; i < TAPS; i++) dline[i] <= dline[i-1];
        band <= '0;
        tap <= '0;
      end
      if (state == RUN) tap <= tap + 4'd1;
      if (state == WAIT) begin
        band_out <= mac_acc;
        band_idx <= band;
        band <= band + 3'd1;
        tap <= '0;
      end
      band_valid <= state == WAIT;
      frame_done <= state == WAIT && band == 3'(BANDS - 1);
      cfg_err <= coef_we && !coef_ok;
      if (coef_we && coef_ok) coef[widx] <= coef_wdata;
    end
  end
endmodule

// File: tb/tb_eq_mac_scheduler.sv
// tb_eq_mac_scheduler: directed scoreboard bench for eq_mac_scheduler with a behavioural MAC
module tb_eq_mac_scheduler;
  logic clk, rst_n, sample_valid, sample_ready, coef_we, cfg_err;
  logic mac_en, mac_clr, band_valid, frame_done;
  logic [15:0] sample_in, coef_wdata, mac_coef, mac_data;
  logic [6:0] coef_addr;
  logic [31:0] band_out;
  logic [2:0] band_idx;
  logic signed [31:0] acc, prod;
  int cyc = 0, checks = 0, errors = 0, n_en = 0, n_clr = 0;
  int ev[8];
  typedef struct {int cyc; int idx; int val; bit fd;} exp_t;
  exp_t q[$];
  eq_mac_scheduler dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_in(sample_in),
    .sample_ready(sample_ready), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .cfg_err(cfg_err), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_coef(mac_coef), .mac_data(mac_data), .mac_acc(acc), .band_valid(band_valid),
    .band_idx(band_idx), .band_out(band_out), .frame_done(frame_done)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  assign prod = $signed(mac_coef) * $signed(mac_data);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_en) acc <= (mac_clr ? 32'sd0 : acc) + prod;
  end
  always @(negedge clk) begin
    if (mac_en) n_en++;
    if (mac_clr) n_clr++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (band_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected band_valid: idx %0d out %0h (cycle %0d)", band_idx, band_out, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("band_valid_cycle", cyc, e.cyc);
        chk("band_idx", {29'b0, band_idx}, e.idx);
        chk("band_out", band_out, e.val);
        chk("frame_done", {31'b0, frame_done}, {31'b0, e.fd});
      end
    end else if (frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_alone: got 1 expected 0 (cycle %0d)", cyc);
    end
  end
  task automatic push_frame(input int a, input int n);
    for (int b = 0; b < n; b++) begin
      exp_t e;
      e.cyc = a + 18 + 16*b;
      e.idx = b;
      e.val = ev[b];
      e.fd = b == 7;
      q.push_back(e);
    end
  endtask
  task automatic send(input logic [15:0] s, output int a);
    int n = 0;
    while (!sample_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: sample_ready got 0 expected 1");
    end
    sample_valid = 1;
    sample_in = s;
    a = cyc;
    @(negedge clk);
    sample_valid = 0;
  endtask
  task automatic wr(input logic [2:0] b, input logic [3:0] t, input logic [15:0] d, input bit err);
    coef_we = 1;
    coef_addr = {b, t};
    coef_wdata = d;
    @(negedge clk);
    coef_we = 0;
    chk("cfg_err", {31'b0, cfg_err}, {31'b0, err});
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !sample_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", q.size(), 0);
  endtask
  task automatic chk_reset_outputs();
    chk("rst_sample_ready", {31'b0, sample_ready}, 1);
    chk("rst_mac", {mac_en, mac_clr, mac_coef, mac_data}, 0);
    chk("rst_band", {band_valid, frame_done, cfg_err, band_idx}, 0);
    chk("rst_band_out", band_out, 0);
  endtask
  initial begin
    int a, e0, c0;
    rst_n = 0;
    sample_valid = 0;
    sample_in = 0;
    coef_we = 0;
    coef_addr = 0;
    coef_wdata = 0;
    repeat (8) begin
      @(negedge clk);
      chk_reset_outputs();
      sample_valid = 1'($urandom);
      sample_in = 16'($urandom);
      coef_we = 1'($urandom);
      coef_addr = 7'($urandom);
      coef_wdata = 16'($urandom);
    end
    @(negedge clk);
    sample_valid = 0;
    coef_we = 0;
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_mac_en", {31'b0, mac_en}, 0);
    end
    for (int t = 0; t < 15; t++) wr(3'd0, 4'(t), 16'(t + 1), 0);
    send(16'd100, a);
    ev = '{100, 0, 0, 0, 0, 0, 0, 0};
    push_frame(a, 8);
    send(16'd0, a);
    ev = '{200, 0, 0, 0, 0, 0, 0, 0};
    push_frame(a, 8);
    wait_idle();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    for (int b = 0; b < 8; b++) wr(3'(b), 4'd0, 16'(1 << b), 0);
    e0 = n_en;
    c0 = n_clr;
    send(16'd1000, a);
    ev = '{1000, 2000, 4000, 8000, 16000, 32000, 64000, 128000};
    push_frame(a, 8);
    while (cyc < a + 129) @(negedge clk);
    chk("ready_busy_A129", {31'b0, sample_ready}, 0);
    @(negedge clk);
    chk("ready_back_A130", {31'b0, sample_ready}, 1);
    chk("mac_en_count", n_en - e0, 120);
    chk("mac_clr_count", n_clr - c0, 8);
    wait_idle();
    wr(3'd3, 4'd0, 16'h8000, 0);
    send(16'h8000, a);
    ev = '{-32768, -65536, -131072, 1073741824, -524288, -1048576, -2097152, -4194304};
    push_frame(a, 8);
    wait_idle();
    wr(3'd3, 4'd0, 16'h7fff, 0);
    send(16'h8000, a);
    ev[3] = -1073709056;
    push_frame(a, 8);
    wait_idle();
    send(16'd1, a);
    ev = '{1, 2, 4, 32767, 16, 32, 64, 128};
    push_frame(a, 8);
    while (cyc < a + 40) @(negedge clk);
    wr(3'd2, 4'd0, 16'd999, 1);
    while (cyc < a + 60) @(negedge clk);
    sample_valid = 1;
    sample_in = 16'd5555;
    @(negedge clk);
    sample_valid = 0;
    wait_idle();
    wr(3'd0, 4'hf, 16'd777, 1);
    send(16'd1, a);
    push_frame(a, 8);
    wait_idle();
    coef_we = 1;
    coef_addr = {3'd0, 4'd1};
    coef_wdata = 16'd1;
    send(16'd1000, a);
    coef_we = 0;
    chk("cfg_err_with_handshake", {31'b0, cfg_err}, 0);
    ev = '{1001, 2000, 0, 0, 0, 0, 0, 0};
    push_frame(a, 2);
    while (cyc < a + 49) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 0;
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("abort_queue", q.size(), 0);
    wr(3'd0, 4'd1, 16'd1, 0);
    send(16'd7, a);
    ev = '{0, 0, 0, 0, 0, 0, 0, 0};
    push_frame(a, 8);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("final_queue", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
